// File: rtl/riscv_pkg.sv
// Shared RV32I encoding definitions: instruction classes, opcodes and
// immediate range limits used by the encoder.
package riscv_pkg;

  typedef enum logic [2:0] {
    IcLw    = 3'd0,
    IcSw    = 3'd1,
    IcRtype = 3'd2,
    IcBeq   = 3'd3,
    IcIalu  = 3'd4,
    IcJal   = 3'd5
  } iclass_t;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_IALU = 7'b0010011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam int IMM12_MIN = -2048;
  localparam int IMM12_MAX = 2047;
  localparam int BIMM_MIN  = -4096;
  localparam int BIMM_MAX  = 4094;
  localparam int JIMM_MIN  = -(1 << 20);
  localparam int JIMM_MAX  = (1 << 20) - 2;
  localparam int SHAMT_MAX = 31;

  function automatic logic in_range(input logic [31:0] v, input int lo, input int hi);
    return ($signed(v) >= lo) && ($signed(v) <= hi);
  endfunction

endpackage

// File: rtl/imm_pack.sv
// Places immediate (and funct7) bits into their instruction positions for each
// class and flags immediates that cannot be represented.
module imm_pack
  import riscv_pkg::*;
(
  input  logic [2:0]  iclass,
  input  logic [2:0]  funct3,
  input  logic        funct7b5,
  input  logic [31:0] imm,
  output logic [31:0] imm_bits,
  output logic        imm_err
);

  logic is_shift;
  assign is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);

  always_comb begin
    imm_bits = '0;
    imm_err  = 1'b0;
    case (iclass)
      IcLw: begin
        imm_bits[31:20] = imm[11:0];
        imm_err         = !in_range(imm, IMM12_MIN, IMM12_MAX);
      end
      IcSw: begin
        imm_bits[31:25] = imm[11:5];
        imm_bits[11:7]  = imm[4:0];
        imm_err         = !in_range(imm, IMM12_MIN, IMM12_MAX);
      end
      IcRtype: begin
        imm_bits[31:25] = {1'b0, funct7b5, 5'b0};
      end
      IcBeq: begin
        imm_bits[31]    = imm[12];
        imm_bits[30:25] = imm[10:5];
        imm_bits[11:8]  = imm[4:1];
        imm_bits[7]     = imm[11];
        imm_err         = !in_range(imm, BIMM_MIN, BIMM_MAX) || imm[0];
      end
      IcIalu: begin
        // Shifts reuse the upper immediate bits as a funct7 field.
        if (is_shift) begin
          imm_bits[31:25] = {1'b0, funct7b5, 5'b0};
          imm_bits[24:20] = imm[4:0];
          imm_err         = !in_range(imm, 0, SHAMT_MAX);
        end else begin
          imm_bits[31:20] = imm[11:0];
          imm_err         = !in_range(imm, IMM12_MIN, IMM12_MAX);
        end
      end
      IcJal: begin
        imm_bits[31]    = imm[20];
        imm_bits[30:21] = imm[10:1];
        imm_bits[20]    = imm[11];
        imm_bits[19:12] = imm[19:12];
        imm_err         = !in_range(imm, JIMM_MIN, JIMM_MAX) || imm[0];
      end
      default: imm_err = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Streaming RV32I encoder: one-deep output register with valid/ready handshake,
// write-address counter and handed-off word count.
module instr_encoder
  import riscv_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        iclass,
  input  logic [2:0]        funct3,
  input  logic              funct7b5,
  input  logic [4:0]        rd,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [31:0]       imm,
  input  logic              base_load,
  input  logic [ADDR_W-1:0] base_addr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_err,
  output logic              err_sticky,
  output logic [CNT_W-1:0]  out_count
);

  logic              accept, hs;
  logic [31:0]       imm_bits, enc;
  logic              imm_err;
  logic [ADDR_W-1:0] addr_q, addr_d;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign hs       = out_valid && out_ready;

  imm_pack u_imm_pack (
    .iclass   (iclass),
    .funct3   (funct3),
    .funct7b5 (funct7b5),
    .imm      (imm),
    .imm_bits (imm_bits),
    .imm_err  (imm_err)
  );

  always_comb begin
    enc = NOP_INSTR;
    case (iclass)
      IcLw:    enc = imm_bits | {12'b0, rs1, 3'b010, rd, OP_LW};
      IcSw:    enc = imm_bits | {7'b0, rs2, rs1, 3'b010, 5'b0, OP_SW};
      IcRtype: enc = imm_bits | {7'b0, rs2, rs1, funct3, rd, OP_R};
      IcBeq:   enc = imm_bits | {7'b0, rs2, rs1, 3'b000, 5'b0, OP_BEQ};
      IcIalu:  enc = imm_bits | {12'b0, rs1, funct3, rd, OP_IALU};
      IcJal:   enc = imm_bits | {20'b0, rd, OP_JAL};
      default: enc = NOP_INSTR;
    endcase
    if (imm_err) enc = NOP_INSTR;
  end

  // A word captured during a handshake takes the post-increment address.
  always_comb begin
    addr_d = addr_q;
    if (base_load)  addr_d = base_addr;
    else if (hs)    addr_d = addr_q + ADDR_W'(4);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q     <= '0;
      out_valid  <= 1'b0;
      out_instr  <= '0;
      out_addr   <= '0;
      out_err    <= 1'b0;
      err_sticky <= 1'b0;
      out_count  <= '0;
    end else begin
      addr_q <= addr_d;
      if (base_load)  out_count <= '0;
      else if (hs)    out_count <= out_count + CNT_W'(1);
      if (accept && imm_err) err_sticky <= 1'b1;
      else if (base_load)    err_sticky <= 1'b0;
      if (accept) begin
        out_valid <= 1'b1;
        out_instr <= enc;
        out_addr  <= addr_d;
        out_err   <= imm_err;
      end else if (hs) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: expected words queued at drive time,
// compared when the encoder hands them off.
module tb_instr_encoder;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  iclass = '0;
  logic [2:0]  funct3 = '0;
  logic        funct7b5 = 1'b0;
  logic [4:0]  rd = '0, rs1 = '0, rs2 = '0;
  logic [31:0] imm = '0;
  logic        base_load = 1'b0;
  logic [31:0] base_addr = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_instr;
  logic [31:0] out_addr;
  logic        out_err;
  logic        err_sticky;
  logic [15:0] out_count;

  always #5 clk = ~clk;

  instr_encoder #(.ADDR_W(32), .CNT_W(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .iclass     (iclass),
    .funct3     (funct3),
    .funct7b5   (funct7b5),
    .rd         (rd),
    .rs1        (rs1),
    .rs2        (rs2),
    .imm        (imm),
    .base_load  (base_load),
    .base_addr  (base_addr),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_instr  (out_instr),
    .out_addr   (out_addr),
    .out_err    (out_err),
    .err_sticky (err_sticky),
    .out_count  (out_count)
  );

  typedef struct {
    logic [31:0] instr;
    logic [31:0] addr;
    logic        err;
    logic [2:0]  cls;
  } exp_t;

  exp_t        sb[$];
  int          errors = 0;
  int          checks = 0;
  logic [31:0] exp_addr = '0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  // Minimal opcode decode, standing in for the main decoder's class lookup.
  function automatic logic [2:0] dec_class(input logic [31:0] w);
    case (w[6:0])
      7'b0000011: return 3'd0;
      7'b0100011: return 3'd1;
      7'b0110011: return 3'd2;
      7'b1100011: return 3'd3;
      7'b0010011: return 3'd4;
      7'b1101111: return 3'd5;
      default:    return 3'd7;
    endcase
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (!reset && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check_eq("sb_underflow", 32'(sb.size()), 32'd1);
      end else begin
        e = sb.pop_front();
        check_eq("instr", out_instr, e.instr);
        check_eq("addr", out_addr, e.addr);
        check_eq("err", 32'(out_err), 32'(e.err));
        if (!e.err) check_eq("class", 32'(dec_class(out_instr)), 32'(e.cls));
      end
    end
  end

  task automatic push_exp(input logic [2:0] c, input logic [31:0] w, input logic e_err);
    exp_t e;
    e.instr = w;
    e.addr  = exp_addr;
    e.err   = e_err;
    e.cls   = c;
    sb.push_back(e);
    exp_addr += 32'd4;
  endtask

  task automatic drive(input logic [2:0] c, input logic [2:0] f3, input logic b5,
                       input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
                       input logic [31:0] im);
    iclass = c; funct3 = f3; funct7b5 = b5; rd = d; rs1 = s1; rs2 = s2; imm = im;
    in_valid = 1'b1;
  endtask

  task automatic send(input logic [2:0] c, input logic [2:0] f3, input logic b5,
                      input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
                      input logic [31:0] im, input logic [31:0] w, input logic e_err);
    int n;
    n = 0;
    push_exp(c, w, e_err);
    drive(c, f3, b5, d, s1, s2, im);
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 50);
    if (!in_ready) check_eq("in_ready_timeout", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic load(input logic [31:0] a);
    base_load = 1'b1;
    base_addr = a;
    @(posedge clk);
    #1;
    base_load = 1'b0;
    exp_addr  = a;
  endtask

  task automatic drain();
    for (int i = 0; i < 50; i++) begin
      if (sb.size() == 0 && !out_valid) break;
      @(posedge clk);
      #1;
    end
    check_eq("drain", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_valid", 32'(out_valid), 32'd0);
    check_eq("rst_instr", out_instr, 32'd0);
    check_eq("rst_addr", out_addr, 32'd0);
    check_eq("rst_err", 32'(out_err), 32'd0);
    check_eq("rst_sticky", 32'(err_sticky), 32'd0);
    check_eq("rst_count", 32'(out_count), 32'd0);
    check_eq("rst_in_ready", 32'(in_ready), 32'd1);
    reset = 1'b0;

    load(32'h100);
    send(3'd0, 3'd0, 1'b0, 5'd5, 5'd2, 5'd0, 32'd8, 32'h0081_2283, 1'b0);
    check_eq("lw_latency", 32'(out_valid), 32'd1);
    drain();

    load(32'h100);
    send(3'd1, 3'd0, 1'b0, 5'd0, 5'd2, 5'd6, 32'd12, 32'h0061_2623, 1'b0);
    send(3'd2, 3'd0, 1'b0, 5'd3, 5'd1, 5'd2, 32'd0, 32'h0020_81B3, 1'b0);
    send(3'd2, 3'd0, 1'b1, 5'd3, 5'd1, 5'd2, 32'd0, 32'h4020_81B3, 1'b0);
    drain();
    check_eq("count3", 32'(out_count), 32'd3);
    check_eq("sticky_clean", 32'(err_sticky), 32'd0);

    send(3'd3, 3'd0, 1'b0, 5'd0, 5'd1, 5'd2, -32'sd4, 32'hFE20_8EE3, 1'b0);
    send(3'd5, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd2048, 32'h0010_00EF, 1'b0);
    send(3'd4, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, -32'sd1, 32'hFFF0_0093, 1'b0);
    send(3'd4, 3'd5, 1'b1, 5'd1, 5'd2, 5'd0, 32'd3, 32'h4031_5093, 1'b0);
    send(3'd0, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, -32'sd2048, 32'h8000_2003, 1'b0);
    send(3'd1, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd2047, 32'h7E00_2FA3, 1'b0);
    send(3'd3, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd4094, 32'h7E00_0FE3, 1'b0);
    send(3'd5, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, -32'sd1048576, 32'h8000_006F, 1'b0);
    drain();

    send(3'd3, 3'd0, 1'b0, 5'd0, 5'd1, 5'd2, 32'd3, NOP_INSTR, 1'b1);
    check_eq("sticky_set", 32'(err_sticky), 32'd1);
    send(3'd4, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd4096, NOP_INSTR, 1'b1);
    send(3'd4, 3'd1, 1'b0, 5'd1, 5'd0, 5'd0, 32'd32, NOP_INSTR, 1'b1);
    send(3'd6, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd0, NOP_INSTR, 1'b1);
    send(3'd5, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd1048576, NOP_INSTR, 1'b1);
    drain();
    check_eq("sticky_hold", 32'(err_sticky), 32'd1);
    load(32'h0);
    check_eq("sticky_clr", 32'(err_sticky), 32'd0);
    check_eq("count_clr", 32'(out_count), 32'd0);

    // Backpressure: first word is captured, second waits for five stalled cycles.
    out_ready = 1'b0;
    push_exp(3'd4, 32'h0050_0113, 1'b0);
    drive(3'd4, 3'd0, 1'b0, 5'd2, 5'd0, 5'd0, 32'd5);
    @(posedge clk);
    #1;
    push_exp(3'd4, 32'h0060_0193, 1'b0);
    drive(3'd4, 3'd0, 1'b0, 5'd3, 5'd0, 5'd0, 32'd6);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_eq("stall_in_ready", 32'(in_ready), 32'd0);
      check_eq("stall_instr", out_instr, 32'h0050_0113);
      check_eq("stall_addr", out_addr, 32'h0);
      check_eq("stall_count", 32'(out_count), 32'd0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check_eq("release_addr", out_addr, 32'h4);
    send(3'd0, 3'd0, 1'b0, 5'd7, 5'd1, 5'd0, 32'd4, 32'h0040_A383, 1'b0);
    send(3'd2, 3'd7, 1'b0, 5'd4, 5'd5, 5'd6, 32'd0, 32'h0062_F233, 1'b0);
    drain();
    check_eq("count4", 32'(out_count), 32'd4);

    // Reset while a word is held: it must be dropped.
    out_ready = 1'b0;
    send(3'd4, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd1, 32'h0010_0093, 1'b0);
    check_eq("held_valid", 32'(out_valid), 32'd1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    void'(sb.pop_front());
    check_eq("rst2_valid", 32'(out_valid), 32'd0);
    check_eq("rst2_addr", out_addr, 32'd0);
    check_eq("rst2_count", 32'(out_count), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
Streaming RV32I instruction encoder, the inverse of the main decoder. Takes decoded fields (class, registers, immediate, funct bits) and produces 32-bit machine words, each tagged with an instruction-memory write address. Used by the boot/program loader and by the bench so that encoder output round-trips through the existing decoder. Covers exactly the decoder's set: lw, sw, R-type, beq, I-type ALU, jal.

Parameters:
ADDR_W, 32, width of out_addr and base_addr
CNT_W, 16, width of out_count

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
in_valid  input  1  field bundle valid
in_ready  output  1  encoder can accept a bundle
iclass  input  3  instruction class, iclass_t: LW=0, SW=1, RTYPE=2, BEQ=3, IALU=4, JAL=5
funct3  input  3  used by RTYPE/IALU only
funct7b5  input  1  RTYPE sub/sra select; IALU srai select
rd  input  5  destination register
rs1  input  5  source 1
rs2  input  5  source 2
imm  input  32  signed byte immediate/offset
base_load  input  1  load address counter
base_addr  input  ADDR_W  new start address, word aligned
out_valid  output  1  encoded word valid
out_ready  input  1  consumer accepts word
out_instr  output  32  encoded instruction
out_addr  output  ADDR_W  write address of out_instr
out_err  output  1  this word replaced by NOP due to bad fields
err_sticky  output  1  any error since reset/base_load
out_count  output  CNT_W  words handed off since reset/base_load

Behaviour:
- Reset (sync, high): out_valid=0, out_instr=0, out_addr=0, out_err=0, err_sticky=0, out_count=0, address counter=0. Reset mid-transfer drops the held word.
- in_ready = !out_valid || out_ready (single output register, no bubble under continuous flow). Input accepted when in_valid && in_ready.
- Latency: accepted bundle appears on out_* the next cycle. out_instr/out_addr/out_err held stable while out_valid && !out_ready.
- Encoding (opcode/funct3 forced where fixed):
  LW: imm[11:0],rs1,010,rd,0000011.
  SW: imm[11:5],rs2,rs1,010,imm[4:0],0100011.
  RTYPE: {0,funct7b5,00000},rs2,rs1,funct3,rd,0110011.
  BEQ: imm[12],imm[10:5],rs2,rs1,000,imm[4:1],imm[11],1100011.
  IALU: imm[11:0],rs1,funct3,rd,0010011; if funct3 is 001/101: {0,funct7b5,00000},imm[4:0].
  JAL: imm[20],imm[10:1],imm[11],imm[19:12],rd,1101111.
- Error rules: LW/SW/IALU imm outside [-2048,2047]; shift shamt outside [0,31]; BEQ imm outside [-4096,4094] or odd; JAL imm outside [-2^20,2^20-2] or odd; iclass 6/7. On error: out_instr=0x00000013 (NOP), out_err=1, err_sticky set; word still counted and addressed.
- Address: out_addr = counter value when the word is captured; counter += 4 on each output handshake (out_valid && out_ready), wraps modulo 2^ADDR_W.
- base_load: counter=base_addr, out_count=0, err_sticky=0 next cycle; wins over a simultaneous handshake increment. A word already held in the output register keeps its captured address.
- out_count increments on each output handshake, wraps.

Decomposition:
- riscv_pkg: iclass_t enum, opcode constants (OP_LW, OP_SW, OP_R, OP_BEQ, OP_IALU, OP_JAL), NOP_INSTR=32'h00000013, imm range constants.
- One combinational sub-module imm_pack (iclass, funct3, funct7b5, imm -> placed immediate bits + range error); top holds handshake, output register and counters.

Test Plan:
- base_load 0x100; LW rd=5 rs1=2 imm=8 -> out_instr 0x00812283, out_addr 0x100, latency 1.
- SW rs2=6 rs1=2 imm=12 then RTYPE add rd=3 rs1=1 rs2=2 (funct3 000, b5 0), then b5=1 -> 0x00612623 @0x100, 0x002081B3 @0x104, 0x402081B3 @0x108; out_count=3.
- BEQ rs1=1 rs2=2 imm=-4 -> 0xFE208EE3; JAL rd=1 imm=2048 -> 0x001000EF; each decoded by maindec back to matching class.
- BEQ imm=3 and IALU imm=4096 -> both 0x00000013, out_err=1, err_sticky=1; base_load clears err_sticky and out_count.
- out_ready=0 for 5 cycles with in_valid=1 -> in_ready=0, out_* stable, counter frozen; release -> one word per cycle, addresses +4 each.
- Reset asserted while out_valid=1 and out_ready=0 -> next cycle out_valid=0, out_addr=0, out_count=0.
